regfile_wb_arbiter: RTL and testbench

- Writeback arbiter that shares the two register-file write ports among N_REQ result producers: ALU pipe 0, ALU pipe 1, the load/store unit and the mul/div unit.
- Grants at most two writes per cycle and never grants two writes to the same register in one cycle.
- Drives the register-file write ports from a registered output stage.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/wb_rr_picker.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the writeback path.
//   REG_AW / REG_DW : default register address / data widths
//   REG_ZERO        : hardwired-zero register address (writes are dropped)
//   wb_req_t        : one producer's write request {valid, addr, data}
//   onehot_idx()    : index of the set bit of a one-hot vector (0 if none)
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    onehot_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) onehot_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between result producers, the arbiter and the register file.
//   req_valid/req_addr/req_data : packed producer requests (producer i at [i*AW +: AW])
//   req_ready                   : per-producer acceptance, combinational
//   reg_w_*_1 / reg_w_*_2       : register-file write ports (older / younger grant)
//   conflict_cnt                : refused-request performance counter
// master = producers + register file side, slave = arbiter.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                reg_w_en_1;
  logic [AW-1:0]       reg_w_addr_1;
  logic [DW-1:0]       reg_w_data_1;
  logic                reg_w_en_2;
  logic [AW-1:0]       reg_w_addr_2;
  logic [DW-1:0]       reg_w_data_2;
  logic [31:0]         conflict_cnt;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, reg_w_en_1, reg_w_addr_1, reg_w_data_1,
    input  reg_w_en_2, reg_w_addr_2, reg_w_data_2, conflict_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, reg_w_en_1, reg_w_addr_1, reg_w_data_1,
    output reg_w_en_2, reg_w_addr_2, reg_w_data_2, conflict_cnt
  );
endinterface

// File: rtl/wb_rr_picker.sv
// Round-robin pick among the auxiliary writeback requesters.
//   req      : auxiliary request vector (bit k = requester k+2)
//   excl     : requesters not eligible this pick
//   ptr      : aux-relative index to start searching from
//   pick     : one-hot winner (all zero if none eligible)
//   next_ptr : index after the winner, wrapping; ptr if nothing picked
module wb_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] excl,
  input  logic [2:0]   ptr,
  output logic [N-1:0] pick,
  output logic [2:0]   next_ptr
);
  logic found;

  always_comb begin
    pick     = '0;
    next_ptr = ptr;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && (j == (int'(ptr) + k) % N) && req[j] && !excl[j]) begin
          found    = 1'b1;
          pick[j]  = 1'b1;
          next_ptr = 3'((j + 1) % N);
        end
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the two register-file write ports among N_REQ
// producers (0 = older pipe, 1 = younger pipe, 2.. = auxiliary units).
// At most two grants per cycle, never two to the same register; grants are
// registered and driven on the write ports the following cycle.
//   clk, reset (async, active-low)
//   bus (slave modport of regfile_wb_arbiter_if): requests, ready, write ports
// Build option: define WB_PERF_CNT_EN to count cycles with a refused request
// on conflict_cnt; otherwise conflict_cnt is tied to 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int STARVE_MAX = 7,
  parameter int AW         = REG_AW,
  parameter int DW         = REG_DW
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NAUX = (N_REQ > 2) ? N_REQ - 2 : 1;
  localparam int SW   = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]    addr [N_REQ];
  logic [DW-1:0]    data [N_REQ];
  logic [N_REQ-1:0] cand, zero_req, g1_vec, g2_vec, grant, elig;
  logic             g1_hit, g2_hit, use_p1, use_p2;
  logic [AW-1:0]    g1_addr, g2_addr;
  logic [DW-1:0]    g1_data, g2_data;
  logic [NAUX-1:0]  aux_v, promo_v, promo_pick, rr_pick1, rr_pick2, excl2;
  // rr_ptr is aux-relative: 0 means requester 2
  logic [2:0]       rr_ptr, rr_ptr_d, rr_nxt1, rr_nxt2, p_idx, p_nxt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr[i]     = bus.req_addr[i*AW +: AW];
      data[i]     = bus.req_data[i*DW +: DW];
      zero_req[i] = bus.req_valid[i] && (addr[i] == AW'(REG_ZERO));
      cand[i]     = bus.req_valid[i] && (addr[i] != AW'(REG_ZERO));
    end
  end

  // only the lowest-index promoted auxiliary jumps the queue in a cycle
  assign promo_pick = promo_v & (~promo_v + NAUX'(1));

  // first grant: promoted aux, then 0, then 1, then round-robin aux
  always_comb begin
    g1_vec = '0;
    use_p1 = 1'b0;
    if (|promo_pick) begin
      for (int k = 0; k < N_REQ - 2; k++) g1_vec[k+2] = promo_pick[k];
    end else if (cand[0]) begin
      g1_vec[0] = 1'b1;
    end else if (cand[1]) begin
      g1_vec[1] = 1'b1;
    end else if (|rr_pick1) begin
      use_p1 = 1'b1;
      for (int k = 0; k < N_REQ - 2; k++) g1_vec[k+2] = rr_pick1[k];
    end
    g1_hit  = |g1_vec;
    g1_addr = '0;
    g1_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      g1_addr = g1_addr | ({AW{g1_vec[i]}} & addr[i]);
      g1_data = g1_data | ({DW{g1_vec[i]}} & data[i]);
    end
  end

  // second-grant candidates must not collide with the first grant's register
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = cand[i] && !g1_vec[i] && (addr[i] != g1_addr);
    end
    excl2 = '1;
    for (int k = 0; k < N_REQ - 2; k++) excl2[k] = !elig[k+2];
  end

  always_comb begin
    g2_vec = '0;
    use_p2 = 1'b0;
    if (g1_hit) begin
      if (elig[0]) begin
        g2_vec[0] = 1'b1;
      end else if (elig[1]) begin
        g2_vec[1] = 1'b1;
      end else if (|rr_pick2) begin
        use_p2 = 1'b1;
        for (int k = 0; k < N_REQ - 2; k++) g2_vec[k+2] = rr_pick2[k];
      end
    end
    g2_hit  = |g2_vec;
    g2_addr = '0;
    g2_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      g2_addr = g2_addr | ({AW{g2_vec[i]}} & addr[i]);
      g2_data = g2_data | ({DW{g2_vec[i]}} & data[i]);
    end
  end

  assign grant = g1_vec | g2_vec;

  // pointer follows the last auxiliary granted this cycle
  always_comb begin
    p_idx = onehot_idx(8'(promo_pick));
    p_nxt = (int'(p_idx) == NAUX - 1) ? 3'd0 : p_idx + 3'd1;
    if (use_p2)            rr_ptr_d = rr_nxt2;
    else if (use_p1)       rr_ptr_d = rr_nxt1;
    else if (|promo_pick)  rr_ptr_d = p_nxt;
    else                   rr_ptr_d = rr_ptr;
  end

  generate
    if (N_REQ > 2) begin : g_aux
      logic [SW-1:0] starve [NAUX];

      always_comb begin
        for (int k = 0; k < NAUX; k++) begin
          aux_v[k]   = cand[k+2];
          promo_v[k] = aux_v[k] && (starve[k] == SW'(STARVE_MAX));
        end
      end

      wb_rr_picker #(.N(NAUX)) u_pick1 (
        .req(aux_v), .excl('0), .ptr(rr_ptr), .pick(rr_pick1), .next_ptr(rr_nxt1)
      );
      wb_rr_picker #(.N(NAUX)) u_pick2 (
        .req(aux_v), .excl(excl2), .ptr(rr_ptr), .pick(rr_pick2), .next_ptr(rr_nxt2)
      );

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rr_ptr <= 3'd0;
          for (int k = 0; k < NAUX; k++) starve[k] <= '0;
        end else begin
          rr_ptr <= rr_ptr_d;
          for (int k = 0; k < NAUX; k++) begin
            if (!aux_v[k] || grant[k+2])            starve[k] <= '0;
            else if (starve[k] != SW'(STARVE_MAX))  starve[k] <= starve[k] + SW'(1);
          end
        end
      end
    end else begin : g_noaux
      assign aux_v    = '0;
      assign promo_v  = '0;
      assign rr_pick1 = '0;
      assign rr_pick2 = '0;
      assign rr_nxt1  = 3'd0;
      assign rr_nxt2  = 3'd0;
      assign rr_ptr   = 3'd0;
    end
  endgenerate

  assign bus.req_ready = reset ? (grant | zero_req) : '0;

  // address/data hold when a port carries no grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.reg_w_en_1   <= 1'b0;
      bus.reg_w_addr_1 <= '0;
      bus.reg_w_data_1 <= '0;
      bus.reg_w_en_2   <= 1'b0;
      bus.reg_w_addr_2 <= '0;
      bus.reg_w_data_2 <= '0;
    end else begin
      bus.reg_w_en_1 <= g1_hit;
      bus.reg_w_en_2 <= g2_hit;
      if (g1_hit) begin
        bus.reg_w_addr_1 <= g1_addr;
        bus.reg_w_data_1 <= g1_data;
      end
      if (g2_hit) begin
        bus.reg_w_addr_2 <= g2_addr;
        bus.reg_w_data_2 <= g2_data;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 perf_cnt <= 32'd0;
    else if (|(cand & ~grant))  perf_cnt <= perf_cnt + 32'd1;
  end

  assign bus.conflict_cnt = perf_cnt;
`else
  assign bus.conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (N_REQ=4, AW=5, DW=32).
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic    clk;
  logic    reset;
  wb_req_t tb_req [4];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      exp_cnt_after_conflict;

`ifdef WB_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  regfile_wb_arbiter_if #(.N_REQ(4), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.N_REQ(4), .STARVE_MAX(7), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]         = tb_req[i].valid;
      bus.req_addr[i*5 +: 5]   = tb_req[i].addr;
      bus.req_data[i*32 +: 32] = tb_req[i].data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    tb_req[i[1:0]].valid = v;
    tb_req[i[1:0]].addr  = a;
    tb_req[i[1:0]].data  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_p1(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, " en1"}, 32'(bus.reg_w_en_1), 32'(en));
    chk({tag, " addr1"}, 32'(bus.reg_w_addr_1), 32'(a));
    chk({tag, " data1"}, bus.reg_w_data_1, d);
  endtask

  task automatic chk_p2(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, " en2"}, 32'(bus.reg_w_en_2), 32'(en));
    chk({tag, " addr2"}, 32'(bus.reg_w_addr_2), 32'(a));
    chk({tag, " data2"}, bus.reg_w_data_2, d);
  endtask

  initial begin
    reset = 1'b0;
    clear_all();
    set_req(0, 1'b1, 5'd3, 32'h11);
    #1;
    chk_p1("reset", 1'b0, 5'd0, 32'h0);
    chk_p2("reset", 1'b0, 5'd0, 32'h0);
    chk("reset ready", 32'(bus.req_ready), 32'h0);
    chk("reset cnt", bus.conflict_cnt, 32'h0);

    @(negedge clk);
    reset = 1'b1;

    // 1: two distinct writes, both granted
    set_req(0, 1'b1, 5'd3, 32'h11);
    set_req(1, 1'b1, 5'd4, 32'h22);
    #1 chk("t1 ready", 32'(bus.req_ready), 32'b0011);
    @(negedge clk);
    clear_all();
    chk_p1("t1", 1'b1, 5'd3, 32'h11);
    chk_p2("t1", 1'b1, 5'd4, 32'h22);

    // 2: same address on 0 and 1, 0 wins, 1 follows
    set_req(0, 1'b1, 5'd7, 32'h33);
    set_req(1, 1'b1, 5'd7, 32'h44);
    #1 chk("t2 ready a", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    set_req(0, 1'b0, 5'd0, 32'h0);
    chk_p1("t2a", 1'b1, 5'd7, 32'h33);
    chk("t2a en2", 32'(bus.reg_w_en_2), 32'h0);
    #1 chk("t2 ready b", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    clear_all();
    chk_p1("t2b", 1'b1, 5'd7, 32'h44);
    chk("t2b en2", 32'(bus.reg_w_en_2), 32'h0);
    exp_cnt_after_conflict = PERF;
    chk("t2 cnt", bus.conflict_cnt, 32'(exp_cnt_after_conflict));

    // 3: address-0 request takes no slot
    set_req(0, 1'b1, 5'd0, 32'hDEAD);
    set_req(2, 1'b1, 5'd9, 32'h55);
    #1 chk("t3 ready", 32'(bus.req_ready), 32'b0101);
    @(negedge clk);
    clear_all();
    chk_p1("t3", 1'b1, 5'd9, 32'h55);
    chk_p2("t3 hold", 1'b0, 5'd4, 32'h22);
    chk("t3 cnt", bus.conflict_cnt, 32'(exp_cnt_after_conflict));
    @(negedge clk);
    chk_p1("idle hold", 1'b0, 5'd9, 32'h55);

    // 4: req3 starves behind 0/1, promoted after 7 refusals
    set_req(0, 1'b1, 5'd1, 32'h101);
    set_req(1, 1'b1, 5'd2, 32'h202);
    set_req(3, 1'b1, 5'd5, 32'h66);
    for (int c = 0; c < 7; c++) begin
      #1 chk($sformatf("t4 refused c%0d", c + 1), 32'(bus.req_ready), 32'b0011);
      @(negedge clk);
    end
    #1 chk("t4 promoted ready", 32'(bus.req_ready), 32'b1001);
    @(negedge clk);
    clear_all();
    chk_p1("t4", 1'b1, 5'd5, 32'h66);
    chk_p2("t4", 1'b1, 5'd1, 32'h101);

    // 5: round-robin between aux units
    set_req(2, 1'b1, 5'd10, 32'h77);
    set_req(3, 1'b1, 5'd11, 32'h88);
    #1 chk("t5 ready both", 32'(bus.req_ready), 32'b1100);
    @(negedge clk);
    chk_p1("t5a", 1'b1, 5'd10, 32'h77);
    chk_p2("t5a", 1'b1, 5'd11, 32'h88);
    set_req(1, 1'b1, 5'd12, 32'h99);
    #1 chk("t5 ready rr0", 32'(bus.req_ready), 32'b0110);
    @(negedge clk);
    chk_p1("t5b", 1'b1, 5'd12, 32'h99);
    chk_p2("t5b", 1'b1, 5'd10, 32'h77);
    #1 chk("t5 ready rr1", 32'(bus.req_ready), 32'b1010);
    @(negedge clk);
    chk_p2("t5c", 1'b1, 5'd11, 32'h88);
    #1 chk("t5 ready rr2", 32'(bus.req_ready), 32'b0110);
    @(negedge clk);
    clear_all();
    chk_p2("t5d", 1'b1, 5'd10, 32'h77);
    @(negedge clk);
    chk("t5 idle en1", 32'(bus.reg_w_en_1), 32'h0);
    chk("t5 idle en2", 32'(bus.reg_w_en_2), 32'h0);

    // 6: asynchronous reset while a write is on the port
    set_req(0, 1'b1, 5'd13, 32'hAA);
    @(negedge clk);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd6, 32'hBB);
    chk("t6 pre en1", 32'(bus.reg_w_en_1), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk_p1("t6 rst", 1'b0, 5'd0, 32'h0);
    chk_p2("t6 rst", 1'b0, 5'd0, 32'h0);
    chk("t6 rst ready", 32'(bus.req_ready), 32'h0);
    chk("t6 rst cnt", bus.conflict_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("t6 post ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    clear_all();
    chk_p1("t6 post", 1'b1, 5'd6, 32'hBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
